fir_mac_seq: RTL

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq_if.sv | 39 +++
 rtl/fir_mac_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq_if.sv
// -----------------------------------------------------------------------------
// fir_mac_seq_if
// Handshake and coefficient-port bundle for the sequential FIR MAC.
//   slave  modport : filter side (fir_mac_seq)
//   master modport : producer/consumer side (system or testbench)
// Signals:
//   in_valid/in_data/in_ready     sample offer, accepted on in_valid && in_ready
//   coef_we/coef_addr/coef_wdata  coefficient write port
//   out_valid/out_data/out_ready  result handshake
//   busy                          filter is computing or holding a result
// -----------------------------------------------------------------------------
interface fir_mac_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 32
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_ready;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_wdata;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_ready;
  logic                         busy;

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac_seq.sv
// -----------------------------------------------------------------------------
// fir_mac_seq
// Sequential single-multiplier FIR filter. Each accepted sample is shifted
// into a TAPS-deep delay line, then one tap per cycle is multiplied and
// accumulated. The result is rounded (round-half-up, arithmetic shift by
// SHIFT) and saturated to DATA_WIDTH before being presented on the output
// handshake.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset (clears state, delay line, coefs)
//   io_bus  fir_mac_seq_if.slave: sample in, coefficient write, result out,
//           busy
// Timing: accept at edge N -> out_valid high after edge N+TAPS+1.
// -----------------------------------------------------------------------------
module fir_mac_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int TAPS       = 32,
  parameter int SHIFT      = 15
) (
  input  logic          clk,
  input  logic          rst,
  fir_mac_seq_if.slave  io_bus
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int IW = $clog2(TAPS + 1);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX  =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN  =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic signed [DATA_WIDTH-1:0] r_x [TAPS];
  logic signed [COEF_WIDTH-1:0] r_c [TAPS];

  logic [IW-1:0]                r_idx;
  logic signed [PW-1:0]         r_prod_p0;
  logic                         r_vld_p0;
  logic signed [ACC_WIDTH-1:0]  r_acc_p1;
  logic                         r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_out_data;

  logic                         w_accept;
  logic                         w_coef_wr;
  logic                         w_tap_live;
  logic                         w_last;
  logic [AW-1:0]                w_rd_idx;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_sum;

  // Add half an output LSB, then arithmetic shift; one guard bit keeps the
  // addition from overflowing at the positive end of the accumulator range.
  function automatic logic signed [ACC_WIDTH:0] round_acc(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH:0] t;
    t = {a[ACC_WIDTH-1], a};
    t = t + RND_HALF;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_out(
    input logic signed [ACC_WIDTH:0] v
  );
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  assign w_accept   = io_bus.in_valid && (r_state == S_IDLE);
  assign w_coef_wr  = io_bus.coef_we && (r_state == S_IDLE) &&
                      (32'(io_bus.coef_addr) < 32'(TAPS));
  // r_idx runs 0..TAPS; the extra count is the drain cycle in which the
  // last product reaches the accumulator and no new tap is read.
  assign w_tap_live = (32'(r_idx) < 32'(TAPS));
  assign w_last     = (32'(r_idx) == 32'(TAPS));
  assign w_rd_idx   = w_tap_live ? r_idx[AW-1:0] : '0;

  assign w_prod     = PW'(r_x[w_rd_idx]) * PW'(r_c[w_rd_idx]);
  assign w_prod_ext = ACC_WIDTH'(r_prod_p0);
  assign w_acc_sum  = r_vld_p0 ? (r_acc_p1 + w_prod_ext) : r_acc_p1;

  assign io_bus.in_ready  = (r_state == S_IDLE);
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.in_valid)  w_state_nxt = S_MAC;
      S_MAC:   if (w_last)           w_state_nxt = S_OUT;
      S_OUT:   if (io_bus.out_ready) w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
      r_idx       <= '0;
      r_prod_p0   <= '0;
      r_vld_p0    <= 1'b0;
      r_acc_p1    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // Coefficient write shares the IDLE cycle with a possible accept; the
      // first coefficient read happens one cycle later, so it sees the write.
      if (w_coef_wr) r_c[io_bus.coef_addr] <= io_bus.coef_wdata;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x[0] <= io_bus.in_data;
            for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
            r_acc_p1 <= '0;
            r_idx    <= '0;
            r_vld_p0 <= 1'b0;
          end
        end
        S_MAC: begin
          // p0: product of the current tap
          r_vld_p0 <= w_tap_live;
          if (w_tap_live) begin
            r_prod_p0 <= w_prod;
            r_idx     <= r_idx + IW'(1);
          end
          // p1: accumulate the previous tap's product
          r_acc_p1 <= w_acc_sum;
          if (w_last) begin
            r_out_data  <= sat_out(round_acc(w_acc_sum));
            r_out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (io_bus.out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
